// File: rtl/cus47_mapper.sv
// cus47_mapper
//   Sub-CPU address line generator. Derives the 6809 E/Q bus phases from
//   CLK_6M, decodes NUM_CH programmable chip-select windows, and holds a
//   banked-ROM latch, a VBLANK interrupt latch with write acknowledge and a
//   kickable watchdog that issues a timed reset pulse.
//
//   Ports
//     CLK_6M     in   master clock, all state on rising edge
//     RES        in   synchronous active-high reset
//     nVBLK      in   vertical blank, active low
//     nWE        in   sub CPU write strobe, active low
//     A          in   sub CPU address [15:0]
//     D          in   data captured by the bank latch [BANK_W-1:0]
//     MQ, ME     out  main CPU Q/E phases
//     SUBQ, SUBE out  sub CPU Q/E phases (inverted main phases)
//     nCS        out  active-low window selects [NUM_CH-1:0]
//     nBUFEN     out  active-low data buffer enable
//     BANK       out  registered bank select [BANK_W-1:0]
//     nIRQ       out  active-low VBLANK interrupt
//     nRES       out  active-low watchdog reset request
//
//   Watchdog states
//     state   | meaning
//     S_RUN   | counting VBLANK falls, kicks clear the count
//     S_PULSE | driving nRES low for RES_PULSE clocks, kicks/falls ignored
module cus47_mapper #(
    parameter int                   NUM_CH         = 8,
    parameter logic [NUM_CH*16-1:0] CH_BASE        = '0,
    parameter logic [NUM_CH*16-1:0] CH_MASK        = '0,
    parameter logic [NUM_CH-1:0]    BUFEN_MASK     = NUM_CH'(8'h3F),
    parameter logic [15:0]          BANK_ADDR      = 16'h8800,
    parameter logic [15:0]          BANK_AMASK     = 16'hF800,
    parameter int                   BANK_W         = 2,
    parameter logic [15:0]          IRQACK_ADDR    = 16'h8400,
    parameter logic [15:0]          WDOG_ADDR      = 16'h8000,
    parameter int                   WATCHDOG_WIDTH = 4,
    parameter int                   RES_PULSE      = 64
) (
    input  logic              CLK_6M,
    input  logic              RES,
    input  logic              nVBLK,
    input  logic              nWE,
    input  logic [15:0]       A,
    input  logic [BANK_W-1:0] D,
    output logic              MQ,
    output logic              ME,
    output logic              SUBQ,
    output logic              SUBE,
    output logic [NUM_CH-1:0] nCS,
    output logic              nBUFEN,
    output logic [BANK_W-1:0] BANK,
    output logic              nIRQ,
    output logic              nRES
);

    localparam int PCW = (RES_PULSE > 1) ? $clog2(RES_PULSE) : 1;
    localparam logic [15:0] REG_AMASK = 16'hFC00;

    typedef enum logic {S_RUN, S_PULSE} state_t;

    state_t                    state;
    logic [1:0]                ph;
    logic [1:0]                ph_next;
    logic                      vblk_d;
    logic                      fall;
    logic                      wr;
    logic                      bank_hit;
    logic                      ack_hit;
    logic                      kick_hit;
    logic [NUM_CH-1:0]         hit;
    logic [WATCHDOG_WIDTH-1:0] wdog;
    logic [WATCHDOG_WIDTH-1:0] wdog_next;
    logic [PCW-1:0]            pcnt;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (A & CH_MASK[16*i +: 16]) == (CH_BASE[16*i +: 16] & CH_MASK[16*i +: 16]);
        end
    end

    // Selects are forced inactive while the bus is held in reset.
    assign nCS    = RES ? '1 : ~hit;
    assign nBUFEN = RES ? 1'b1 : ~|(hit & BUFEN_MASK);

    assign ph_next  = ph + 2'd1;
    // One write strobe per bus cycle, on the last E-high clock.
    assign wr       = ~nWE & (ph == 2'd3);
    assign fall     = vblk_d & ~nVBLK;
    assign bank_hit = (A & BANK_AMASK) == (BANK_ADDR & BANK_AMASK);
    assign ack_hit  = (A & REG_AMASK) == (IRQACK_ADDR & REG_AMASK);
    assign kick_hit = (A & REG_AMASK) == (WDOG_ADDR & REG_AMASK);

    always_comb begin
        wdog_next = wdog;
        if (wr && kick_hit) begin
            wdog_next = '0;
        end else if (fall) begin
            wdog_next = wdog + WATCHDOG_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (RES) begin
            ph     <= 2'd0;
            ME     <= 1'b0;
            MQ     <= 1'b0;
            SUBE   <= 1'b1;
            SUBQ   <= 1'b1;
            BANK   <= '0;
            vblk_d <= 1'b1;
            nIRQ   <= 1'b1;
            nRES   <= 1'b1;
            wdog   <= '0;
            pcnt   <= '0;
            state  <= S_RUN;
        end else begin
            // Phase outputs are registered from the upcoming phase so they
            // line up with ph itself.
            ph   <= ph_next;
            ME   <= ph_next[1];
            MQ   <= ph_next[1] ^ ph_next[0];
            SUBE <= ~ph_next[1];
            SUBQ <= ~(ph_next[1] ^ ph_next[0]);

            if (wr && bank_hit) begin
                BANK <= D;
            end

            vblk_d <= nVBLK;
            // A new VBLANK edge outranks an acknowledge in the same clock.
            if (fall) begin
                nIRQ <= 1'b0;
            end else if (wr && ack_hit) begin
                nIRQ <= 1'b1;
            end

            case (state)
                S_RUN: begin
                    wdog <= wdog_next;
                    if (wdog_next[WATCHDOG_WIDTH-1]) begin
                        state <= S_PULSE;
                        nRES  <= 1'b0;
                        pcnt  <= '0;
                    end
                end
                S_PULSE: begin
                    pcnt <= pcnt + PCW'(1);
                    if (pcnt == PCW'(RES_PULSE - 1)) begin
                        state <= S_RUN;
                        nRES  <= 1'b1;
                        wdog  <= '0;
                    end
                end
                default: begin
                    state <= S_RUN;
                    nRES  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cus47_mapper.sv
// Scoreboard bench for cus47_mapper: stimulus pushes expectations stamped
// with the clock edge they apply to; the monitor compares on the falling edge.
module tb_cus47_mapper;

    localparam logic [127:0] TB_BASE = {16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE,
                                        16'hFFFE, 16'h8400, 16'h8000, 16'h0000};
    localparam logic [127:0] TB_MASK = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                        16'hFFFF, 16'hFC00, 16'hF000, 16'hE000};

    logic        clk = 1'b0;
    logic        RES = 1'b1;
    logic        nVBLK = 1'b1;
    logic        nWE = 1'b1;
    logic [15:0] A = 16'h1FFF;
    logic [1:0]  D = 2'b00;
    logic        MQ, ME, SUBQ, SUBE, nBUFEN, nIRQ, nRES;
    logic [7:0]  nCS;
    logic [1:0]  BANK;

    cus47_mapper #(
        .NUM_CH(8), .CH_BASE(TB_BASE), .CH_MASK(TB_MASK), .BUFEN_MASK(8'h3F),
        .BANK_ADDR(16'h8800), .BANK_AMASK(16'hF800), .BANK_W(2),
        .IRQACK_ADDR(16'h8400), .WDOG_ADDR(16'h8000),
        .WATCHDOG_WIDTH(4), .RES_PULSE(64)
    ) dut (
        .CLK_6M(clk), .RES(RES), .nVBLK(nVBLK), .nWE(nWE), .A(A), .D(D),
        .MQ(MQ), .ME(ME), .SUBQ(SUBQ), .SUBE(SUBE), .nCS(nCS), .nBUFEN(nBUFEN),
        .BANK(BANK), .nIRQ(nIRQ), .nRES(nRES)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [1:0] m_ph = 2'd0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        m_ph <= RES ? 2'd0 : m_ph + 2'd1;
    end

    function automatic logic [15:0] observe(int sel);
        case (sel)
            0:       return {12'd0, ME, MQ, SUBE, SUBQ};
            1:       return {8'd0, nCS};
            2:       return {15'd0, nBUFEN};
            3:       return {14'd0, BANK};
            4:       return {15'd0, nIRQ};
            default: return {15'd0, nRES};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (observe(sb[i].sel) !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %h expected %h",
                             sb[i].name, cyc, observe(sb[i].sel), sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: check at cyc %0d never sampled", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic chk(input int d, input string nm, input int sel, input logic [15:0] e);
        sb.push_back('{cyc + d, nm, sel, e});
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ph3();
        for (int i = 0; i < 8 && m_ph != 2'd3; i++) step();
    endtask

    task automatic wr_bus(input logic [15:0] addr, input logic [1:0] data);
        wait_ph3();
        A = addr;
        D = data;
        nWE = 1'b0;
        step();
        nWE = 1'b1;
    endtask

    task automatic vfall();
        nVBLK = 1'b0;
        step();
        nVBLK = 1'b1;
        step();
    endtask

    // {ME,MQ,SUBE,SUBQ} for ph 0..3
    logic [3:0] ph_tab [4] = '{4'h3, 4'h6, 4'hC, 4'h9};

    initial begin
        step(2);
        chk(0, "rst_ncs", 1, 16'h00FF);
        chk(0, "rst_bufen", 2, 16'h1);
        chk(0, "rst_phase", 0, 16'h3);
        chk(0, "rst_bank", 3, 16'h0);
        chk(0, "rst_nirq", 4, 16'h1);
        chk(0, "rst_nres", 5, 16'h1);
        step();

        RES = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk(0, "phase", 0, {12'd0, ph_tab[k % 4]});
            step();
        end

        A = 16'h1FFF; #1;
        chk(0, "win0_hit_ncs", 1, 16'h00FE);
        chk(0, "win0_hit_bufen", 2, 16'h0);
        step();
        A = 16'h2000; #1;
        chk(0, "no_hit_ncs", 1, 16'h00FF);
        chk(0, "no_hit_bufen", 2, 16'h1);
        step();
        A = 16'h8400; #1;
        chk(0, "overlap_ncs", 1, 16'h00F9);
        step();
        A = 16'hFFFF; #1;
        chk(0, "unbuffered_ncs", 1, 16'h003F);
        chk(0, "unbuffered_bufen", 2, 16'h1);
        step();

        wr_bus(16'h8C00, 2'b10);
        chk(0, "bank_wr_ph3", 3, 16'h2);
        step();
        while (m_ph != 2'd1) step();
        A = 16'h8C00; D = 2'b01; nWE = 1'b0;
        step();
        nWE = 1'b1;
        chk(1, "bank_wr_ph1", 3, 16'h2);
        step(2);

        nVBLK = 1'b0; #1;
        chk(0, "irq_before_edge", 4, 16'h1);
        step();
        chk(0, "irq_fall", 4, 16'h0);
        step(2);
        wr_bus(16'h8400, 2'b00);
        chk(0, "irq_ack", 4, 16'h1);
        step(3);
        chk(0, "irq_level_no_reassert", 4, 16'h1);
        nVBLK = 1'b1;
        step(2);
        wait_ph3();
        nVBLK = 1'b0; A = 16'h8400; nWE = 1'b0;
        step();
        nWE = 1'b1;
        chk(0, "irq_fall_beats_ack", 4, 16'h0);
        nVBLK = 1'b1;
        step();

        wr_bus(16'h8000, 2'b00);
        for (int f = 1; f <= 7; f++) vfall();
        chk(0, "wdog_7_falls", 5, 16'h1);
        nVBLK = 1'b0;
        step();
        chk(0, "wdog_trip", 5, 16'h0);
        chk(63, "pulse_last_low", 5, 16'h0);
        chk(64, "pulse_end", 5, 16'h1);
        nVBLK = 1'b1;
        step(8);
        vfall();
        wr_bus(16'h8000, 2'b00);
        step(70);

        for (int f = 1; f <= 7; f++) vfall();
        chk(0, "wdog_cleared_after_pulse", 5, 16'h1);
        wr_bus(16'h8000, 2'b00);
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 4; f++) vfall();
            chk(0, "kicked_no_trip", 5, 16'h1);
            if (r < 2) wr_bus(16'h8000, 2'b00);
        end
        for (int f = 0; f < 4; f++) vfall();
        chk(0, "second_trip", 5, 16'h0);
        step(10);
        chk(0, "pre_res_bank", 3, 16'h2);
        chk(0, "pre_res_nirq", 4, 16'h0);
        RES = 1'b1;
        step();
        chk(0, "res_mid_pulse_nres", 5, 16'h1);
        chk(0, "res_mid_pulse_nirq", 4, 16'h1);
        chk(0, "res_mid_pulse_bank", 3, 16'h0);
        step(3);

        errors += sb.size();
        checks += sb.size();
        for (int i = 0; i < sb.size(); i++)
            $display("FAIL %s: check at cyc %0d left pending", sb[i].name, sb[i].cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
